// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: HD44780 8-bit bus sequencer with power-up init and valid/ready byte writes; define LCD_BUSY_POLL_EN to poll the busy flag instead of fixed waits after user writes
module lcd_cmd_sequencer #(
  parameter int T_PWRUP  = 750000,
  parameter int T_SETUP  = 4,
  parameter int T_EN     = 24,
  parameter int T_HOLD   = 4,
  parameter int T_CMD    = 2000,
  parameter int T_CLR    = 82000,
  parameter int POLL_MAX = 4096
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  input  logic       blon_in,
  output logic       init_done,
  output logic       busy,
  inout  wire  [7:0] lcd_data,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_on,
  output logic       lcd_blon
);
  localparam int CW = 20;
  typedef enum logic [3:0] {
    PWRUP, INIT_LOAD, SETUP, ENH, HOLD, WAIT, IDLE
`ifdef LCD_BUSY_POLL_EN
    , P_SETUP, P_ENH, P_HOLD
`endif
  } state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, ld_val;
  logic ld, last, long_wait, drive, rs_q;
  logic [2:0] idx;
  logic [7:0] data_q;
  function automatic logic [7:0] rom(input logic [2:0] i);
    return i == 3'd2 ? 8'h0C : i == 3'd3 ? 8'h01 : i == 3'd4 ? 8'h06 : 8'h38;
  endfunction
  assign last      = cnt == '0;
  assign long_wait = !rs_q && data_q inside {8'h01, 8'h02, 8'h03};
  assign drive     = state inside {SETUP, ENH, HOLD};
  assign lcd_data  = drive ? data_q : 8'hzz;
  assign lcd_rs    = drive & rs_q;
  assign busy      = state != IDLE;
  assign cmd_ready = state == IDLE && init_done;
`ifdef LCD_BUSY_POLL_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  logic [PW-1:0] polls;
  logic bsy_q;
  assign lcd_en = state == ENH || state == P_ENH;
  assign lcd_rw = state inside {P_SETUP, P_ENH, P_HOLD};
  // busy-poll attempt counter and busy flag sampled on the last EN-high cycle of a read
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      polls <= '0;
      bsy_q <= 1'b0;
    end else begin
      if (state == HOLD) polls <= '0;
      else if (state == P_HOLD && last) polls <= polls + PW'(1);
      if (state == P_ENH && last) bsy_q <= lcd_data[7];
    end
`else
  assign lcd_en = state == ENH;
  assign lcd_rw = 1'b0;
`endif
  // next state and counter reload on state entry
  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = '0;
    case (state)
      PWRUP:     if (cnt == CW'(T_PWRUP - 1)) begin nxt = INIT_LOAD; ld = 1'b1; end
      INIT_LOAD: begin nxt = SETUP; ld = 1'b1; ld_val = CW'(T_SETUP - 1); end
      SETUP:     if (last) begin nxt = ENH; ld = 1'b1; ld_val = CW'(T_EN - 1); end
      ENH:       if (last) begin nxt = HOLD; ld = 1'b1; ld_val = CW'(T_HOLD - 1); end
      HOLD:      if (last) begin
        ld = 1'b1;
`ifdef LCD_BUSY_POLL_EN
        if (init_done) begin
          nxt    = P_SETUP;
          ld_val = CW'(T_SETUP - 1);
        end else
`endif
        begin
          nxt    = WAIT;
          ld_val = long_wait ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
        end
      end
      WAIT:      if (last) nxt = (init_done || idx == 3'd4) ? IDLE : INIT_LOAD;
      IDLE:      if (cmd_valid && init_done) begin nxt = SETUP; ld = 1'b1; ld_val = CW'(T_SETUP - 1); end
`ifdef LCD_BUSY_POLL_EN
      P_SETUP:   if (last) begin nxt = P_ENH; ld = 1'b1; ld_val = CW'(T_EN - 1); end
      P_ENH:     if (last) begin nxt = P_HOLD; ld = 1'b1; ld_val = CW'(T_HOLD - 1); end
      P_HOLD:    if (last) begin
        ld = 1'b1;
        if (!bsy_q) nxt = IDLE;
        else if (polls == PW'(POLL_MAX - 1)) begin nxt = WAIT; ld_val = CW'(T_CLR - 1); end
        else begin nxt = P_SETUP; ld_val = CW'(T_SETUP - 1); end
      end
`endif
      default:   nxt = PWRUP;
    endcase
  end
  // state, shared timer (counts up only during power-up), byte latch and init progress
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state     <= PWRUP;
      cnt       <= '0;
      idx       <= '0;
      data_q    <= '0;
      rs_q      <= 1'b0;
      init_done <= 1'b0;
      lcd_on    <= 1'b0;
      lcd_blon  <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= ld ? ld_val : state == PWRUP ? cnt + CW'(1) : cnt - CW'(!last);
      lcd_on   <= 1'b1;
      lcd_blon <= blon_in;
      if (state == INIT_LOAD) begin
        data_q <= rom(idx);
        rs_q   <= 1'b0;
      end
      if (state == IDLE && cmd_valid && init_done) begin
        data_q <= cmd_data;
        rs_q   <= cmd_rs;
      end
      if (state == WAIT && last && !init_done) begin
        idx       <= idx + 3'd1;
        init_done <= idx == 3'd4;
      end
    end
endmodule
